// File: rtl/otsu_binarize_packer.sv
// otsu_binarize_packer: thresholds a raster pixel stream and writes bit-packed bytes to memory
module otsu_binarize_packer #(
  parameter int          IMAGE_WIDTH  = 8,
  parameter int          IMAGE_HEIGHT = 8,
  parameter logic [31:0] OUT_BASE     = 32'h0010_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  threshold,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        pix_ready,
  output logic        mem_en,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_data_out,
  output logic        busy,
  output logic        processing_done
);
  localparam int N = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] ALL = CW'(N);
  typedef enum logic [1:0] {IDLE, RUN, WRITE, DONE} state_t;
  state_t        r_state, w_next;
  logic [7:0]    r_thr, r_sr, r_mem_data, w_byte;
  logic [CW-1:0] r_pix_cnt;
  logic [2:0]    r_k;
  logic [31:0]   r_byte_idx, r_mem_addr;
  logic          w_idle, w_accept, w_close;
  always_comb begin
    w_idle = r_state == IDLE || r_state == DONE;
    w_accept = r_state == RUN && pix_valid;
    w_close = r_k == 3'd7 || r_pix_cnt == LAST;
    w_byte = r_sr | (8'(pix_data > r_thr) << r_k);
    w_next = r_state;
    if (w_idle && start) w_next = RUN;
    else if (w_accept && w_close) w_next = WRITE;
    else if (r_state == WRITE) w_next = r_pix_cnt == ALL ? DONE : RUN;
  end
  // the completed byte and its address are captured on the accepting edge so WRITE follows directly
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_thr <= '0;
      r_sr <= '0;
      r_k <= '0;
      r_pix_cnt <= '0;
      r_byte_idx <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_idle && start) begin
        r_thr <= threshold;
        r_sr <= '0;
        r_k <= '0;
        r_pix_cnt <= '0;
        r_byte_idx <= '0;
      end
      if (w_accept) begin
        r_pix_cnt <= r_pix_cnt + 1'b1;
        r_k <= r_k + 1'b1;
        r_sr <= w_close ? 8'h00 : w_byte;
        if (w_close) begin
          r_mem_addr <= OUT_BASE + r_byte_idx;
          r_mem_data <= w_byte;
        end
      end
      if (r_state == WRITE) r_byte_idx <= r_byte_idx + 1'b1;
    end
  end
  assign pix_ready = r_state == RUN;
  assign mem_en = r_state == WRITE;
  assign mem_rw = r_state == WRITE;
  assign mem_addr = r_mem_addr;
  assign mem_data_out = r_mem_data;
  assign busy = r_state == RUN || r_state == WRITE;
  assign processing_done = r_state == DONE;
endmodule

// File: tb/tb_otsu_binarize_packer.sv
// tb_otsu_binarize_packer: scoreboard bench for the 8x8 packer and a 3x3 variant
module tb_otsu_binarize_packer;
  localparam logic [31:0] BASE = 32'h0010_0000;
  typedef struct packed {logic [31:0] a; logic [7:0] d;} wr_t;
  typedef struct {logic [7:0] thr; int mode; bit gaps; bit inject; logic [7:0] exp;} vec_t;
  logic clk = 0, reset_a = 1, reset_b = 1, start = 0, pix_valid = 0;
  logic [7:0] threshold = 0, pix_data = 0;
  logic rdy_a, en_a, rw_a, busy_a, done_a, rdy_b, en_b, rw_b, busy_b, done_b;
  logic [31:0] addr_a, addr_b;
  logic [7:0] data_a, data_b;
  int pass_cnt = 0, tot_cnt = 0, acc = 0, nw = 0, cyc = 0, last_cyc = 0;
  bit gap_mode = 0, sel = 0;
  wr_t qa[$], qb[$];
  wr_t ea, eb;
  vec_t tv[4];

  otsu_binarize_packer dut_a (
    .clk(clk), .reset(reset_a), .start(start), .threshold(threshold),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(rdy_a),
    .mem_en(en_a), .mem_rw(rw_a), .mem_addr(addr_a), .mem_data_out(data_a),
    .busy(busy_a), .processing_done(done_a));

  otsu_binarize_packer #(.IMAGE_WIDTH(3), .IMAGE_HEIGHT(3)) dut_b (
    .clk(clk), .reset(reset_b), .start(start), .threshold(threshold),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(rdy_b),
    .mem_en(en_b), .mem_rw(rw_b), .mem_addr(addr_b), .mem_data_out(data_b),
    .busy(busy_b), .processing_done(done_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    else pass_cnt++;
  endtask

  always @(negedge clk) begin
    if (en_a) begin
      if (qa.size() == 0) check("unexpected_write_a", 32'(en_a), 32'd0);
      else begin
        ea = qa.pop_front();
        check("addr_a", addr_a, ea.a);
        check("data_a", 32'(data_a), 32'(ea.d));
        check("rw_a", 32'(rw_a), 32'd1);
        check("pixels_before_write", 32'(acc), 32'(8 * nw + 8));
        if (!gap_mode && nw > 0) check("write_spacing", 32'(cyc - last_cyc), 32'd9);
        last_cyc = cyc;
        nw++;
      end
    end
    if (rw_a && !en_a) check("rw_without_en_a", 32'(rw_a), 32'd0);
    if (en_b) begin
      if (qb.size() == 0) check("unexpected_write_b", 32'(en_b), 32'd0);
      else begin
        eb = qb.pop_front();
        check("addr_b", addr_b, eb.a);
        check("data_b", 32'(data_b), 32'(eb.d));
        check("rw_b", 32'(rw_b), 32'd1);
      end
    end
  end

  function automatic logic [7:0] pixel(input int mode, input int i);
    return mode == 0 ? ((i % 8) < 4 ? 8'h3F : 8'hC0) : mode == 1 ? ((i % 2) != 0 ? 8'h81 : 8'h80) : 8'hFF;
  endfunction

  task automatic do_start(input logic [7:0] thr);
    start = 1;
    threshold = thr;
    acc = 0;
    nw = 0;
    @(posedge clk); #1;
    start = 0;
    check("busy_after_start", 32'(sel ? busy_b : busy_a), 32'd1);
    check("ready_after_start", 32'(sel ? rdy_b : rdy_a), 32'd1);
    check("done_cleared", 32'(sel ? done_b : done_a), 32'd0);
  endtask

  task automatic send(input logic [7:0] d);
    int t;
    t = 0;
    pix_valid = 1;
    pix_data = d;
    @(negedge clk);
    while (!(sel ? rdy_b : rdy_a) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("pix_ready_timeout", 32'(t), 32'd0);
    @(posedge clk); #1;
    pix_valid = 0;
    acc++;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!(sel ? done_b : done_a) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("done_reached", 32'(sel ? done_b : done_a), 32'd1);
    repeat (3) @(negedge clk);
    check("done_held", 32'(sel ? done_b : done_a), 32'd1);
    check("busy_in_done", 32'(sel ? busy_b : busy_a), 32'd0);
    check("ready_in_done", 32'(sel ? rdy_b : rdy_a), 32'd0);
    check("writes_outstanding", 32'(sel ? qb.size() : qa.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_a(input string tag);
    check({tag, "_ready"}, 32'(rdy_a), 32'd0);
    check({tag, "_en"}, 32'(en_a), 32'd0);
    check({tag, "_rw"}, 32'(rw_a), 32'd0);
    check({tag, "_busy"}, 32'(busy_a), 32'd0);
    check({tag, "_done"}, 32'(done_a), 32'd0);
    check({tag, "_addr"}, addr_a, 32'd0);
    check({tag, "_data"}, 32'(data_a), 32'd0);
  endtask

  task automatic frame(input vec_t v);
    gap_mode = v.gaps;
    do_start(v.thr);
    for (int b = 0; b < 8; b++) qa.push_back('{a: BASE + 32'(b), d: v.exp});
    for (int i = 0; i < 64; i++) begin
      if (v.gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      if (v.inject && i == 20) begin
        start = 1;
        threshold = 8'hFF;
      end
      send(pixel(v.mode, i));
      start = 0;
    end
    wait_done();
  endtask

  initial begin
    tv[0] = '{thr: 8'h7F, mode: 0, gaps: 0, inject: 0, exp: 8'hF0};
    tv[1] = '{thr: 8'h80, mode: 1, gaps: 0, inject: 0, exp: 8'hAA};
    tv[2] = '{thr: 8'h7F, mode: 0, gaps: 1, inject: 0, exp: 8'hF0};
    tv[3] = '{thr: 8'h7F, mode: 0, gaps: 0, inject: 1, exp: 8'hF0};
    repeat (3) @(posedge clk); #1;
    chk_reset_a("por");
    reset_a = 0;
    @(posedge clk); #1;
    chk_reset_a("idle");
    for (int k = 0; k < 4; k++) frame(tv[k]);
    // abort mid-byte: nothing may be written and the next frame restarts at the base address
    gap_mode = 0;
    do_start(8'h7F);
    for (int i = 0; i < 5; i++) send(pixel(0, i));
    reset_a = 1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_a("midframe_reset");
    reset_a = 0;
    repeat (5) @(posedge clk); #1;
    check("no_write_after_reset", 32'(qa.size()), 32'd0);
    frame(tv[0]);
    // 3x3 frame: one full byte, then a single pixel zero-filled to 0x01
    reset_a = 1;
    reset_b = 0;
    sel = 1;
    @(posedge clk); #1;
    do_start(8'h00);
    qb.push_back('{a: BASE, d: 8'hFF});
    qb.push_back('{a: BASE + 32'd1, d: 8'h01});
    for (int i = 0; i < 9; i++) send(8'hFF);
    wait_done();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/otsu_binarize_packer.md
OTSU_BINARIZE_PACKER -- requirements
Module: otsu_binarize_packer

Interface
REQ-001 Parameter IMAGE_WIDTH, default 8, pixels per row.
REQ-002 Parameter IMAGE_HEIGHT, default 8, rows per frame.
REQ-003 Parameter OUT_BASE, default 32'h00100000, byte address of the first packed output byte.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to begin a frame; samples threshold.
REQ-007 threshold  input  8  Otsu threshold from the threshold stage.
REQ-008 pix_valid  input  1  pix_data valid this cycle.
REQ-009 pix_data  input  8  grayscale pixel, raster order.
REQ-010 pix_ready  output  1  block accepts a pixel this cycle.
REQ-011 mem_en  output  1  memory access strobe.
REQ-012 mem_rw  output  1  1 = write; only asserted with mem_en.
REQ-013 mem_addr  output  32  write byte address.
REQ-014 mem_data_out  output  8  packed binary byte.
REQ-015 busy  output  1  frame in progress.
REQ-016 processing_done  output  1  frame fully written; level.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, WRITE and DONE.
REQ-018 IDLE/DONE + start: latch threshold, clear pixel and byte counters, clear processing_done, go to RUN.
REQ-019 start in RUN or WRITE SHALL be ignored; latched threshold SHALL NOT change during a frame.
REQ-020 pix_ready SHALL be 1 only in RUN; a pixel is accepted on an edge where pix_valid && pix_ready.
REQ-021 Binarization: bit = 1 iff pix_data > latched threshold (unsigned); equal gives 0.
REQ-022 Packing: the k-th accepted pixel of a byte (k = 0..7) SHALL occupy bit k (LSB = leftmost pixel).
REQ-023 When the 8th pixel of a byte or the frame's final pixel is accepted, the next state SHALL be WRITE.
REQ-024 WRITE SHALL last exactly one cycle with mem_en=1, mem_rw=1, mem_addr=OUT_BASE+byte_index, mem_data_out=packed byte.
REQ-025 Write latency: the write cycle SHALL immediately follow the clock edge that accepted the completing pixel.
REQ-026 After WRITE: byte_index increments, shift register clears, return to RUN; after the last byte go to DONE.
REQ-027 Frame size N=IMAGE_WIDTH*IMAGE_HEIGHT; byte count ceil(N/8); partial final byte SHALL zero-fill unused upper bits.
REQ-028 Pixel counter SHALL be wide enough for N without wrap; pixels beyond N SHALL NOT be accepted.
REQ-029 In DONE: processing_done=1, busy=0, pix_ready=0, held until next start or reset.
REQ-030 busy SHALL be 1 in RUN and WRITE, otherwise 0.
REQ-031 Outside WRITE, mem_en=0 and mem_rw=0; mem_addr and mem_data_out hold their last values.

Reset
REQ-032 reset SHALL override all inputs including start in the same cycle.
REQ-033 After reset: state IDLE; pix_ready, mem_en, mem_rw, busy, processing_done = 0; mem_addr = 0; mem_data_out = 0; counters, shift register and latched threshold = 0.
REQ-034 Reset mid-frame SHALL discard the partial byte with no further write; the next start SHALL restart at OUT_BASE.

Verification
REQ-035 8x8 frame, pixels 0x3F for column<4 and 0xC0 otherwise, threshold 0x7F, pix_valid held high -> eight writes to 0x00100000..0x00100007, each 0xF0, one every 9 cycles; processing_done=1 after the last write.
REQ-036 threshold 0x80; pixels alternate 0x80 and 0x81 -> every byte 0xAA.
REQ-037 IMAGE_WIDTH=3, IMAGE_HEIGHT=3, all pixels 0xFF, threshold 0x00 -> writes 0xFF to OUT_BASE and 0x01 to OUT_BASE+1, then DONE.
REQ-038 Random pix_valid gaps on the first scenario -> identical write sequence; mem_en never asserted before 8 pixels are accepted.
REQ-039 Assert reset after 5 accepted pixels -> no write; all outputs at reset values; a new start writes the first byte to 0x00100000.
REQ-040 start pulsed and threshold changed to 0xFF mid-frame -> both ignored; outputs match the first scenario.
